// File: rtl/fp_pkg.sv
// fp_pkg: flag indices, format helpers and FSM state type
// shared by the sequential floating-point divider.
package fp_pkg;

  localparam int FLG_NX = 0;
  localparam int FLG_UF = 1;
  localparam int FLG_OF = 2;
  localparam int FLG_DZ = 3;
  localparam int FLG_NV = 4;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECIP,
    S_MUL,
    S_NORM,
    S_DONE
  } state_t;

  function automatic int fp_exp_w(input int t);
    return (t == 16) ? 5 : 8;
  endfunction

  function automatic int fp_frac_w(input int t);
    return (t == 16) ? 10 : 23;
  endfunction

  function automatic int fp_bias(input int t);
    return (t == 16) ? 15 : 127;
  endfunction

  function automatic logic [31:0] fp_nan(input int t);
    return (t == 16) ? 32'h0000_7E00 : 32'h7FC0_0000;
  endfunction

  function automatic logic [31:0] fp_inf(input int t,
                                         input logic s);
    return (t == 16) ? {16'h0, s, 15'h7C00}
                     : {s, 31'h7F80_0000};
  endfunction

  function automatic logic [31:0] fp_zero(input int t,
                                          input logic s);
    return (t == 16) ? {16'h0, s, 15'h0}
                     : {s, 31'h0};
  endfunction

endpackage

// File: rtl/mant_mul_seq.sv
// mant_mul_seq: N-bit right-shifting shift-add multiplier,
// one multiplier bit per step, LSB first, 2N-bit product.
import fp_pkg::*;

module mant_mul_seq #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           i_start,
  input  logic           i_step,
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  output logic           o_done,
  output logic [2*N-1:0] o_prod
);

  localparam int CW = $clog2(N);

  logic [N-1:0]   r_mcand;
  logic [2*N-1:0] r_prod;
  logic [CW-1:0]  r_cnt;
  logic [N:0]     w_sum;

  assign w_sum = {1'b0, r_prod[2*N-1:N]}
               + (r_prod[0] ? {1'b0, r_mcand} : '0);

  // load operands on start, then add-and-shift once per step
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mcand <= '0;
      r_prod  <= '0;
      r_cnt   <= '0;
    end else if (i_start) begin
      r_mcand <= i_a;
      r_prod  <= {{N{1'b0}}, i_b};
      r_cnt   <= CW'(N - 1);
    end else if (i_step) begin
      r_prod <= {w_sum, r_prod[N-1:1]};
      if (r_cnt != '0)
        r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_done = i_step & (r_cnt == '0);
  assign o_prod = r_prod;

endmodule

// File: rtl/fp_div_seq.sv
// fp_div_seq: a / b computed as a * recip(b) with a serial
// mantissa multiplier. FP_DIV_RNE_EN selects round-to-nearest-even.
import fp_pkg::*;

module fp_div_seq #(
  parameter int TYPE = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [TYPE-1:0] a_bits,
  input  logic [TYPE-1:0] b_bits,
  output logic [TYPE-1:0] recip_operand,
  input  logic [TYPE-1:0] recip_bits,
  input  logic [4:0]      recip_flags,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [TYPE-1:0] out_bits,
  output logic [4:0]      out_flags
);

  localparam int EXP  = fp_exp_w(TYPE);
  localparam int FRAC = fp_frac_w(TYPE);
  localparam int BIAS = fp_bias(TYPE);
  localparam int N    = FRAC + 1;
  localparam logic signed [10:0] EMAX = 11'((1 << EXP) - 1);

  state_t r_state, w_next;

  logic [TYPE-1:0] r_a, r_b, r_out_bits;
  logic [4:0]      r_out_flags;
  logic [EXP-1:0]  r_r_exp;
  logic            r_rnx;

  logic [EXP-1:0]  w_a_exp, w_b_exp;
  logic [FRAC-1:0] w_a_frac, w_b_frac;
  logic            w_sign;
  logic            w_a_nan, w_a_inf, w_a_zero;
  logic            w_b_nan, w_b_inf, w_b_zero;
  logic            w_special;
  logic [TYPE-1:0] w_spec_bits;
  logic [4:0]      w_spec_flags;

  logic            w_mul_done;
  logic [2*N-1:0]  w_p;
  logic            w_hi, w_disc;
  logic [FRAC-1:0] w_mant, w_mant_r;
  logic signed [10:0] w_exp, w_exp_f;
  logic [TYPE-1:0] w_norm_bits;
  logic [4:0]      w_norm_flags;
  logic            w_unused;

`ifdef FP_DIV_RNE_EN
  logic w_g, w_s, w_up, w_carry;
`endif

  assign w_a_exp  = r_a[TYPE-2 -: EXP];
  assign w_b_exp  = r_b[TYPE-2 -: EXP];
  assign w_a_frac = r_a[FRAC-1:0];
  assign w_b_frac = r_b[FRAC-1:0];
  assign w_sign   = r_a[TYPE-1] ^ r_b[TYPE-1];

  assign w_a_nan  = (&w_a_exp) & (|w_a_frac);
  assign w_a_inf  = (&w_a_exp) & ~(|w_a_frac);
  assign w_a_zero = (w_a_exp == '0);
  assign w_b_nan  = (&w_b_exp) & (|w_b_frac);
  assign w_b_inf  = (&w_b_exp) & ~(|w_b_frac);
  assign w_b_zero = (w_b_exp == '0) & ~(|w_b_frac);

  assign w_unused = ^{recip_bits[TYPE-1], recip_flags[4:1]};

  // special-operand classification, highest priority first
  always_comb begin
    w_special    = 1'b1;
    w_spec_bits  = TYPE'(fp_nan(TYPE));
    w_spec_flags = '0;
    if (w_a_nan | w_b_nan) begin
      w_spec_flags[FLG_NV] = 1'b1;
    end else if ((w_a_inf & w_b_inf) | (w_a_zero & w_b_zero)) begin
      w_spec_flags[FLG_NV] = 1'b1;
    end else if (w_a_inf) begin
      w_spec_bits = TYPE'(fp_inf(TYPE, w_sign));
    end else if (w_b_zero) begin
      w_spec_bits = TYPE'(fp_inf(TYPE, w_sign));
      w_spec_flags[FLG_DZ] = 1'b1;
    end else if (w_a_zero | w_b_inf) begin
      w_spec_bits = TYPE'(fp_zero(TYPE, w_sign));
    end else begin
      w_special = 1'b0;
    end
  end

  mant_mul_seq #(.N(N)) u_mul (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_start ((r_state == S_RECIP) & ~w_special),
    .i_step  (r_state == S_MUL),
    .i_a     ({1'b1, w_a_frac}),
    .i_b     ({1'b1, recip_bits[FRAC-1:0]}),
    .o_done  (w_mul_done),
    .o_prod  (w_p)
  );

  // normalize product, optionally round, range check and pack
  always_comb begin
    w_hi   = w_p[2*N-1];
    w_mant = w_hi ? w_p[2*N-2 -: FRAC] : w_p[2*N-3 -: FRAC];
    w_disc = w_hi ? (|w_p[N-1:0]) : (|w_p[N-2:0]);
    w_exp  = $signed(11'(w_a_exp) + 11'(r_r_exp)
                     - 11'(BIAS) + 11'(w_hi));
`ifdef FP_DIV_RNE_EN
    w_g  = w_hi ? w_p[N-1] : w_p[N-2];
    w_s  = w_hi ? (|w_p[N-2:0]) : (|w_p[N-3:0]);
    w_up = w_g & (w_s | w_mant[0]);
    {w_carry, w_mant_r} = {1'b0, w_mant} + (FRAC+1)'(w_up);
    w_exp_f = $signed(w_exp + 11'(w_carry));
`else
    w_mant_r = w_mant;
    w_exp_f  = w_exp;
`endif
    w_norm_bits  = '0;
    w_norm_flags = '0;
    if (w_exp_f >= EMAX) begin
      w_norm_bits = TYPE'(fp_inf(TYPE, w_sign));
      w_norm_flags[FLG_OF] = 1'b1;
    end else if (w_exp_f <= 11'sd0) begin
      w_norm_bits = TYPE'(fp_zero(TYPE, w_sign));
      w_norm_flags[FLG_UF] = 1'b1;
    end else begin
      w_norm_bits = {w_sign, w_exp_f[EXP-1:0], w_mant_r};
      w_norm_flags[FLG_NX] = w_disc | r_rnx;
    end
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_state <= S_IDLE;
    else
      r_state <= w_next;
  end

  // next-state decode
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (in_valid) w_next = S_RECIP;
      S_RECIP: w_next = w_special ? S_DONE : S_MUL;
      S_MUL:   if (w_mul_done) w_next = S_NORM;
      S_NORM:  w_next = S_DONE;
      S_DONE:  if (out_ready) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // operand capture, reciprocal capture and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a         <= '0;
      r_b         <= '0;
      r_r_exp     <= '0;
      r_rnx       <= 1'b0;
      r_out_bits  <= '0;
      r_out_flags <= '0;
    end else begin
      if ((r_state == S_IDLE) && in_valid) begin
        r_a <= a_bits;
        r_b <= b_bits;
      end
      if (r_state == S_RECIP) begin
        r_r_exp <= recip_bits[TYPE-2 -: EXP];
        r_rnx   <= recip_flags[FLG_NX];
        if (w_special) begin
          r_out_bits  <= w_spec_bits;
          r_out_flags <= w_spec_flags;
        end
      end
      if (r_state == S_NORM) begin
        r_out_bits  <= w_norm_bits;
        r_out_flags <= w_norm_flags;
      end
    end
  end

  assign in_ready      = (r_state == S_IDLE);
  assign out_valid     = (r_state == S_DONE);
  assign out_bits      = r_out_bits;
  assign out_flags     = r_out_flags;
  assign recip_operand = r_b;

endmodule

// File: tb/tb_fp_div_seq.sv
// tb_fp_div_seq: directed bench for fp_div_seq (TYPE=32),
// reciprocal unit replaced by driven recip_bits/recip_flags.
module tb_fp_div_seq;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, out_valid;
  logic [31:0] a_bits = '0, b_bits = '0, recip_bits = '0;
  logic [31:0] recip_operand, out_bits;
  logic [4:0]  recip_flags = '0, out_flags;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  fp_div_seq #(.TYPE(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .a_bits        (a_bits),
    .b_bits        (b_bits),
    .recip_operand (recip_operand),
    .recip_bits    (recip_bits),
    .recip_flags   (recip_flags),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_bits      (out_bits),
    .out_flags     (out_flags)
  );

  // normal path: a, b, recip, rflags, expected bits, expected flags
  localparam logic [31:0] NA [8] = '{
    32'h40C00000, 32'hC0C00000, 32'h3F800000, 32'h3FC00000,
    32'h7F000000, 32'h00800000, 32'h3F800001, 32'h3FC00000};
  localparam logic [31:0] NB [8] = '{
    32'h40000000, 32'h40000000, 32'h40400000, 32'h3FC00000,
    32'h00800000, 32'h7E800000, 32'h3F7FFFFE, 32'h3F2AAAAB};
  localparam logic [31:0] NR [8] = '{
    32'h3F000000, 32'h3F000000, 32'h3EAAAAAA, 32'h3F2AAAAA,
    32'h7E800000, 32'h00800000, 32'h3F800001, 32'h3FC00000};
  localparam logic [4:0] NF [8] = '{
    5'b00000, 5'b00000, 5'b00001, 5'b00001,
    5'b00000, 5'b00000, 5'b00000, 5'b00000};
  localparam logic [31:0] NE [8] = '{
    32'h40400000, 32'hC0400000, 32'h3EAAAAAA, 32'h3F7FFFFF,
    32'h7F800000, 32'h00000000, 32'h3F800002, 32'h40100000};
  localparam logic [4:0] NEF [8] = '{
    5'b00000, 5'b00000, 5'b00001, 5'b00001,
    5'b00100, 5'b00010, 5'b00001, 5'b00000};

  // special path vectors
  localparam logic [31:0] SA [10] = '{
    32'h3F800000, 32'h7FC00000, 32'h7F800000, 32'h00000000,
    32'hFF800000, 32'h00000000, 32'h3F800000, 32'h00400000,
    32'h3F800000, 32'h3F800000};
  localparam logic [31:0] SB [10] = '{
    32'h00000000, 32'h3F800000, 32'h7F800000, 32'h00000000,
    32'h40000000, 32'hC0000000, 32'h7F800000, 32'h40000000,
    32'h80000000, 32'h7FC00001};
  localparam logic [31:0] SR [10] = '{
    32'h7F800000, 32'h3F800000, 32'h00000000, 32'h7F800000,
    32'h3F000000, 32'hBF000000, 32'h00000000, 32'h3F000000,
    32'hFF800000, 32'h00000000};
  localparam logic [4:0] SF [10] = '{
    5'b01000, 5'b00000, 5'b00000, 5'b01000,
    5'b00000, 5'b00000, 5'b00000, 5'b00000,
    5'b01000, 5'b00000};
  localparam logic [31:0] SE [10] = '{
    32'h7F800000, 32'h7FC00000, 32'h7FC00000, 32'h7FC00000,
    32'hFF800000, 32'h80000000, 32'h00000000, 32'h00000000,
    32'hFF800000, 32'h7FC00000};
  localparam logic [4:0] SEF [10] = '{
    5'b01000, 5'b10000, 5'b10000, 5'b10000,
    5'b00000, 5'b00000, 5'b00000, 5'b00000,
    5'b01000, 5'b10000};

  task automatic run_op(input logic [31:0] a, b, rb,
                        input logic [4:0] rf,
                        output logic [31:0] ob,
                        output logic [4:0] of,
                        output int lat);
    @(negedge clk);
    a_bits = a;
    b_bits = b;
    recip_bits = rb;
    recip_flags = rf;
    in_valid = 1'b1;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
      in_valid = 1'b0;
    end while (!out_valid && lat < 100);
    ob = out_bits;
    of = out_flags;
  endtask

  task automatic finish_op;
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    repeat (2) @(negedge clk);
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_hs got in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
    checks++;
    if (out_bits !== 32'h0 || out_flags !== 5'h0) begin
      failures++;
      $display("FAIL reset_out got %h/%b want 0/0",
               out_bits, out_flags);
    end
    checks++;
    if (recip_operand !== 32'h0) begin
      failures++;
      $display("FAIL reset_rop got %h want 0", recip_operand);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_normal;
    logic [31:0] ob;
    logic [4:0]  of;
    int lat;
    for (int i = 0; i < 8; i++) begin
      run_op(NA[i], NB[i], NR[i], NF[i], ob, of, lat);
      checks++;
      if (ob !== NE[i]) begin
        failures++;
        $display("FAIL normal[%0d] bits got %h want %h",
                 i, ob, NE[i]);
      end
      checks++;
      if (of !== NEF[i]) begin
        failures++;
        $display("FAIL normal[%0d] flags got %b want %b",
                 i, of, NEF[i]);
      end
      checks++;
      if (lat !== 27) begin
        failures++;
        $display("FAIL normal[%0d] latency got %0d want 27", i, lat);
      end
      checks++;
      if (recip_operand !== NB[i]) begin
        failures++;
        $display("FAIL normal[%0d] recip_operand got %h want %h",
                 i, recip_operand, NB[i]);
      end
      finish_op();
    end
  endtask

  task automatic test_special;
    logic [31:0] ob;
    logic [4:0]  of;
    int lat;
    for (int i = 0; i < 10; i++) begin
      run_op(SA[i], SB[i], SR[i], SF[i], ob, of, lat);
      checks++;
      if (ob !== SE[i]) begin
        failures++;
        $display("FAIL special[%0d] bits got %h want %h",
                 i, ob, SE[i]);
      end
      checks++;
      if (of !== SEF[i]) begin
        failures++;
        $display("FAIL special[%0d] flags got %b want %b",
                 i, of, SEF[i]);
      end
      checks++;
      if (lat !== 2) begin
        failures++;
        $display("FAIL special[%0d] latency got %0d want 2", i, lat);
      end
      finish_op();
    end
  endtask

  task automatic test_backpressure;
    logic [31:0] ob;
    logic [4:0]  of;
    int lat;
    run_op(32'h40C00000, 32'h40000000, 32'h3F000000, 5'b0,
           ob, of, lat);
    checks++;
    if (ob !== 32'h40400000) begin
      failures++;
      $display("FAIL bp_first got %h want 40400000", ob);
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      a_bits = 32'h3F800000;
      b_bits = 32'h00000000;
      recip_bits = 32'h7F800000;
      recip_flags = 5'b01000;
      @(posedge clk);
      #1;
      checks++;
      if (out_valid !== 1'b1 || in_ready !== 1'b0 ||
          out_bits !== 32'h40400000 || out_flags !== 5'b0 ||
          recip_operand !== 32'h40000000) begin
        failures++;
        $display("FAIL bp_hold[%0d] got v=%b r=%b %h/%b rop=%h want 1 0 40400000/00000 40000000",
                 c, out_valid, in_ready, out_bits, out_flags,
                 recip_operand);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++;
      $display("FAIL bp_release got v=%b r=%b want 0 1",
               out_valid, in_ready);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    checks++;
    if (in_ready !== 1'b0 || recip_operand !== 32'h00000000) begin
      failures++;
      $display("FAIL bp_next_accept got r=%b rop=%h want 0 00000000",
               in_ready, recip_operand);
    end
    @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_bits !== 32'h7F800000 ||
        out_flags !== 5'b01000) begin
      failures++;
      $display("FAIL bp_next_result got v=%b %h/%b want 1 7F800000/01000",
               out_valid, out_bits, out_flags);
    end
    finish_op();
  endtask

  task automatic test_reset_mid;
    logic [31:0] ob;
    logic [4:0]  of;
    int lat;
    @(negedge clk);
    a_bits = 32'h40C00000;
    b_bits = 32'h40000000;
    recip_bits = 32'h3F000000;
    recip_flags = 5'b0;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #2;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      failures++;
      $display("FAIL mid_busy got v=%b r=%b want 0 0",
               out_valid, in_ready);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1 ||
        recip_operand !== 32'h0) begin
      failures++;
      $display("FAIL mid_reset got v=%b r=%b rop=%h want 0 1 0",
               out_valid, in_ready, recip_operand);
    end
    @(negedge clk);
    rst_n = 1'b1;
    run_op(32'h40C00000, 32'h40000000, 32'h3F000000, 5'b0,
           ob, of, lat);
    checks++;
    if (ob !== 32'h40400000 || of !== 5'b0) begin
      failures++;
      $display("FAIL mid_after got %h/%b want 40400000/00000", ob, of);
    end
    checks++;
    if (lat !== 27) begin
      failures++;
      $display("FAIL mid_after_lat got %0d want 27", lat);
    end
    finish_op();
  endtask

  initial begin
    test_reset();
    test_normal();
    test_special();
    test_backpressure();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
